// File: rtl/riscv_regfile_sb.sv
// riscv_regfile_sb: NRD-port integer register file with
// write-back bypass and a per-register busy scoreboard.
module riscv_regfile_sb #(
  parameter int XLEN   = 32,
  parameter int NREGS  = 32,
  parameter int NRD    = 2,
  parameter int BYPASS = 1,
  localparam int AW    = $clog2(NREGS)
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic [NRD*AW-1:0] rd_addr_in,
  output logic [NRD*XLEN-1:0] rd_data_out,
  output logic [NRD-1:0]    rd_busy_out,
  input  logic              wb_we_in,
  input  logic [AW-1:0]     wb_addr_in,
  input  logic [XLEN-1:0]   wb_data_in,
  input  logic              iss_valid_in,
  input  logic [AW-1:0]     iss_rd_in,
  input  logic              flush_in,
  output logic [AW:0]       busy_count_out
);

  localparam bit BP = (BYPASS != 0);

  logic [XLEN-1:0]  regs [NREGS];
  logic [NREGS-1:0] busy;
  logic [NREGS-1:0] busy_nxt;
  logic             wb_ok;
  logic             iss_ok;

  assign wb_ok  = wb_we_in && (wb_addr_in != '0);
  assign iss_ok = iss_valid_in && (iss_rd_in != '0);

  // Issue is applied after the clear so it wins on a same-register collision.
  always_comb begin
    busy_nxt = busy;
    if (flush_in) begin
      busy_nxt = '0;
    end else begin
      if (wb_ok)
        busy_nxt[wb_addr_in] = 1'b0;
      if (iss_ok)
        busy_nxt[iss_rd_in] = 1'b1;
    end
    busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      regs <= '{default: '0};
      busy <= '0;
    end else begin
      if (wb_ok)
        regs[wb_addr_in] <= wb_data_in;
      busy <= busy_nxt;
    end
  end

  for (genvar p = 0; p < NRD; p++) begin : g_rd
    logic [AW-1:0] addr;
    logic          zero;
    logic          hit;

    assign addr = rd_addr_in[p*AW +: AW];
    assign zero = (addr == '0);
    assign hit  = BP && wb_we_in
               && (wb_addr_in == addr);

    always_comb begin
      rd_data_out[p*XLEN +: XLEN] = regs[addr];
      rd_busy_out[p] = busy[addr];
      if (zero) begin
        rd_data_out[p*XLEN +: XLEN] = '0;
        rd_busy_out[p] = 1'b0;
      end else if (hit) begin
        rd_data_out[p*XLEN +: XLEN] = wb_data_in;
        rd_busy_out[p] = 1'b0;
      end
    end
  end

  always_comb begin
    busy_count_out = '0;
    for (int i = 0; i < NREGS; i++)
      busy_count_out = busy_count_out
                     + {{AW{1'b0}}, busy[i]};
  end

endmodule

// File: tb/tb_riscv_regfile_sb.sv
// tb_riscv_regfile_sb: scoreboard bench driving a
// bypassing and a non-bypassing instance in lockstep.
module tb_riscv_regfile_sb;

  localparam int XLEN = 32;
  localparam int NREGS = 32;
  localparam int NRD = 2;
  localparam int AW = 5;

  typedef struct {
    string       tag;
    logic [31:0] v;
  } exp_t;

  logic              clk;
  logic              rst;
  logic [NRD*AW-1:0] rd_addr;
  logic              wb_we;
  logic [AW-1:0]     wb_addr;
  logic [XLEN-1:0]   wb_data;
  logic              iss_v;
  logic [AW-1:0]     iss_rd;
  logic              flush;

  logic [NRD*XLEN-1:0] d_b1, d_b0;
  logic [NRD-1:0]      bz_b1, bz_b0;
  logic [AW:0]         cnt_b1, cnt_b0;

  logic [31:0] m_regs [NREGS];
  logic [31:0] m_busy;
  exp_t        sb [$];
  int          n_chk;
  int          n_err;

  riscv_regfile_sb #(
    .XLEN(XLEN), .NREGS(NREGS),
    .NRD(NRD), .BYPASS(1)
  ) dut (
    .clk_in(clk), .rst_in(rst),
    .rd_addr_in(rd_addr),
    .rd_data_out(d_b1),
    .rd_busy_out(bz_b1),
    .wb_we_in(wb_we),
    .wb_addr_in(wb_addr),
    .wb_data_in(wb_data),
    .iss_valid_in(iss_v),
    .iss_rd_in(iss_rd),
    .flush_in(flush),
    .busy_count_out(cnt_b1)
  );

  riscv_regfile_sb #(
    .XLEN(XLEN), .NREGS(NREGS),
    .NRD(NRD), .BYPASS(0)
  ) dut_nb (
    .clk_in(clk), .rst_in(rst),
    .rd_addr_in(rd_addr),
    .rd_data_out(d_b0),
    .rd_busy_out(bz_b0),
    .wb_we_in(wb_we),
    .wb_addr_in(wb_addr),
    .wb_data_in(wb_data),
    .iss_valid_in(iss_v),
    .iss_rd_in(iss_rd),
    .flush_in(flush),
    .busy_count_out(cnt_b0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h",
               tag, got, exp);
    end
  endtask

  function automatic logic [AW-1:0] pa(input int p);
    return rd_addr[p*AW +: AW];
  endfunction

  task automatic idle();
    rst = 1'b0; wb_we = 1'b0; wb_addr = '0;
    wb_data = '0; iss_v = 1'b0; iss_rd = '0;
    flush = 1'b0;
  endtask

  // Expected values come from the bench model and go
  // through the queue before the DUT outputs are read.
  task automatic sample();
    logic [AW-1:0] a;
    logic          hit;
    #2;
    for (int b = 1; b >= 0; b--) begin
      for (int p = 0; p < NRD; p++) begin
        a = pa(p);
        hit = (b == 1) && wb_we && (wb_addr == a);
        sb.push_back('{$sformatf("b%0d_d%0d_x%0d", b, p, a),
          (a == 0) ? 32'h0 :
          hit ? wb_data : m_regs[a]});
        sb.push_back('{$sformatf("b%0d_bz%0d_x%0d", b, p, a),
          (a == 0) ? 32'h0 :
          {31'h0, m_busy[a] & ~hit}});
      end
      sb.push_back('{$sformatf("b%0d_cnt", b),
        32'($countones(m_busy))});
    end
    for (int b = 1; b >= 0; b--) begin
      for (int p = 0; p < NRD; p++) begin
        exp_t e;
        e = sb.pop_front();
        check(e.tag, (b == 1) ? d_b1[p*XLEN +: XLEN]
                              : d_b0[p*XLEN +: XLEN], e.v);
        e = sb.pop_front();
        check(e.tag, {31'h0, (b == 1) ? bz_b1[p]
                                       : bz_b0[p]}, e.v);
      end
      begin
        exp_t e;
        e = sb.pop_front();
        check(e.tag, (b == 1) ? 32'(cnt_b1)
                              : 32'(cnt_b0), e.v);
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst) begin
      for (int i = 0; i < NREGS; i++) m_regs[i] = '0;
      m_busy = '0;
    end else begin
      if (wb_we && wb_addr != 0)
        m_regs[wb_addr] = wb_data;
      if (flush) begin
        m_busy = '0;
      end else begin
        if (wb_we) m_busy[wb_addr] = 1'b0;
        if (iss_v) m_busy[iss_rd] = 1'b1;
      end
      m_busy[0] = 1'b0;
    end
    @(negedge clk);
    idle();
  endtask

  task automatic rd2(input int a0, input int a1);
    rd_addr = {AW'(a1), AW'(a0)};
  endtask

  initial begin
    n_chk = 0; n_err = 0;
    m_busy = '0;
    for (int i = 0; i < NREGS; i++) m_regs[i] = '0;
    rd_addr = '0;
    idle();

    rst = 1'b1; tick();
    rst = 1'b1; tick();

    for (int a = 0; a < NREGS; a++) begin
      rd2(a, NREGS - 1 - a);
      sample();
      tick();
    end

    wb_we = 1; wb_addr = 5; wb_data = 32'hDEADBEEF;
    tick();
    wb_we = 1; wb_addr = 0; wb_data = 32'h1234;
    tick();
    rd2(5, 0);
    sample();
    check("x5_rd", d_b1[31:0], 32'hDEADBEEF);
    check("x0_rd", d_b1[63:32], 32'h0);
    check("x0_bz", {31'h0, bz_b1[1]}, 32'h0);
    tick();

    rd2(7, 7);
    wb_we = 1; wb_addr = 7; wb_data = 32'hA5A5A5A5;
    sample();
    check("byp_on", d_b1[31:0], 32'hA5A5A5A5);
    check("byp_off", d_b0[31:0], 32'h0);
    tick();
    sample();
    check("byp_off_next", d_b0[31:0], 32'hA5A5A5A5);
    tick();

    iss_v = 1; iss_rd = 3;
    tick();
    rd2(3, 3);
    sample();
    check("x3_busy", {31'h0, bz_b1[0]}, 32'h1);
    check("x3_cnt", 32'(cnt_b1), 32'h1);
    wb_we = 1; wb_addr = 3; wb_data = 32'h33;
    sample();
    check("x3_wb_byp", {31'h0, bz_b1[0]}, 32'h0);
    check("x3_wb_nobyp", {31'h0, bz_b0[0]}, 32'h1);
    tick();
    sample();
    check("x3_cnt_clr", 32'(cnt_b1), 32'h0);
    tick();

    iss_v = 1; iss_rd = 9;
    wb_we = 1; wb_addr = 9; wb_data = 32'h99;
    rd2(9, 0);
    sample();
    tick();
    rd2(9, 9);
    sample();
    check("x9_busy", {31'h0, bz_b0[1]}, 32'h1);
    check("x9_data", d_b0[31:0], 32'h99);
    tick();

    for (int k = 0; k < 3; k++) begin
      iss_v = 1; iss_rd = AW'(4 + 2 * k);
      rd2(4, 6);
      sample();
      tick();
    end
    check("cnt_4", 32'(cnt_b1), 32'h4);
    flush = 1; iss_v = 1; iss_rd = 10;
    rd2(4, 8);
    sample();
    tick();
    rd2(10, 9);
    sample();
    check("flush_cnt", 32'(cnt_b1), 32'h0);
    check("flush_x10", {31'h0, bz_b1[0]}, 32'h0);
    tick();

    iss_v = 1; iss_rd = 12;
    tick();
    wb_we = 1; wb_addr = 12; wb_data = 32'h55;
    tick();
    iss_v = 1; iss_rd = 13;
    rst = 1;
    tick();
    rd2(12, 13);
    sample();
    check("rst_x12", d_b1[31:0], 32'h0);
    check("rst_cnt", 32'(cnt_b0), 32'h0);
    tick();

    for (int n = 0; n < 400; n++) begin
      rd_addr = 10'($urandom);
      if (($urandom % 3) == 0) rd_addr[AW-1:0] = wb_addr;
      wb_we = 1'($urandom);
      wb_addr = 5'($urandom);
      wb_data = $urandom;
      iss_v = 1'($urandom);
      iss_rd = 5'($urandom);
      flush = (($urandom % 16) == 0);
      rst = (($urandom % 64) == 0);
      if ($urandom % 2 == 0)
        rd_addr[AW-1:0] = wb_addr;
      sample();
      tick();
    end

    $display("Result: errors=%0d of %0d checks",
             n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/riscv_regfile_sb.md
Name: riscv_regfile_sb

Overview:
Parametrised integer register file for the pipelined core. It has NRD combinational read ports, one write-back port and an optional same-cycle write-to-read bypass. An integrated scoreboard of per-register busy bits is set at issue and cleared at write-back, so the decode stage can detect RAW hazards without an external structure. It sits between decode (read/issue) and write-back. It replaces the fixed 2-read, 32x32 register file.

Parameters:
XLEN, 32, data width of each register in bits.
NREGS, 32, number of architectural registers (power of two, >=2); register 0 is hardwired zero.
NRD, 2, number of read ports (>=1).
BYPASS, 1, 1 = write-back data and busy-clear are forwarded to read ports in the same cycle; 0 = no forwarding.
Derived: AW = $clog2(NREGS).

Ports:
clk_in  input  1  core clock; all state updates on its rising edge.
rst_in  input  1  synchronous, active-high reset.
rd_addr_in  input  NRD*AW  read addresses; port p uses bits [p*AW +: AW].
rd_data_out  output  NRD*XLEN  read data; port p uses bits [p*XLEN +: XLEN].
rd_busy_out  output  NRD  per-port flag: register has an outstanding write.
wb_we_in  input  1  write-back enable.
wb_addr_in  input  AW  write-back destination register.
wb_data_in  input  XLEN  write-back data.
iss_valid_in  input  1  instruction issued with a destination register.
iss_rd_in  input  AW  destination of the issued instruction; marks that register busy.
flush_in  input  1  pipeline flush; clears all busy bits; register data is untouched.
busy_count_out  output  AW+1  number of registers currently marked busy.

Behaviour:
- Reset (rst_in=1 at a clock edge): all registers become 0 and all busy bits become 0. Issue, write-back and flush inputs are ignored that cycle.
- Reset output values: rd_data_out=0 and rd_busy_out=0 for every port; busy_count_out=0.
- Register 0:
  - Writes to it are ignored; an issue to it never sets a busy bit.
  - Reading it always returns 0 with busy=0, regardless of bypass.
- Write: if wb_we_in=1 and wb_addr_in!=0, regs[wb_addr_in] <= wb_data_in at the clock edge. Writing a non-busy register is legal; the data is stored and the busy bit stays 0.
- Read path (combinational, zero latency):
  - rd_data_out[p] = regs[addr_p].
  - If BYPASS=1, wb_we_in=1, wb_addr_in==addr_p and addr_p!=0, then rd_data_out[p] = wb_data_in instead.
  - With BYPASS=0 the new value appears the cycle after the write edge.
- Busy bits, in priority order per edge (after reset):
  - flush_in=1: all busy bits <= 0. An iss_valid_in in the same cycle is ignored; a write-back in the same cycle still writes data.
  - Otherwise, write-back to r!=0 clears busy[r], and issue to r!=0 sets busy[r].
  - Issue and write-back to the same r in one cycle: issue wins (busy[r]=1, data still written). This models a new producer issued while the old one retires.
  - Issue to an already-busy register: stays busy (single bit, no count per register).
- rd_busy_out[p]:
  - BYPASS=1: busy[addr_p] & ~(wb_we_in & wb_addr_in==addr_p). A same-cycle issue does not affect it until the next cycle.
  - BYPASS=0: busy[addr_p].
- busy_count_out: combinational popcount of the registered busy vector. Its maximum is NREGS-1 (busy[0] is never set).
- Multiple read ports may read the same address simultaneously; each port sees identical values.
- Reset mid-operation: all pending busy state is lost and all data is cleared; the first usable cycle is the one after rst_in deasserts.

Test Plan:
- Reset then read: hold rst_in for 2 cycles, then read x0..x31 on all ports -> every rd_data_out=0, rd_busy_out=0, busy_count_out=0.
- Write/read and x0: wb x5=0xDEADBEEF, then wb x0=0x1234 -> next cycle port0 reads x5=0xDEADBEEF and port1 reads x0=0, busy=0.
- Bypass: BYPASS=1, port0 addr=7, wb x7=0xA5A5A5A5 in the same cycle -> rd_data_out[0]=0xA5A5A5A5 that cycle. With BYPASS=0 the same stimulus -> old value (0) that cycle, 0xA5A5A5A5 the next.
- Scoreboard: issue x3 -> next cycle rd_busy_out for x3=1 and busy_count_out=1. Then wb x3 -> busy=0 in the same cycle (BYPASS=1) and busy_count_out=0 after the edge.
- Simultaneous events:
  - Issue x9 and wb x9 in one cycle -> x9 busy=1 next cycle, data updated.
  - Issue x4, x6, x8 in successive cycles, then flush together with issue x10 -> busy_count_out=0 and x10 not busy.
- Reset mid-operation: issue x12, write x12=0x55, assert rst_in -> x12=0, busy=0, count=0.
